// File: rtl/keypad_scan_tx.sv
// Generic FIFO: WIDTH x DEPTH storage with occupancy count.
// Latency: write visible at rd_dat the cycle after wr_vld; rd_dat is the combinational head.
// Backpressure: a write while full is accepted only when a read happens in the same cycle.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_rdy,
  output logic [WIDTH-1:0] rd_dat,
  output logic [AW:0]      count,
  output logic             full
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full   = (count == (AW+1)'(DEPTH));
  assign do_rd  = rd_rdy && (count != '0);
  // When full, the slot being written is the one being read this cycle.
  assign do_wr  = wr_vld && (!full || do_rd);
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// Keypad scanner: 4x4 matrix scan, snapshot debounce, ASCII encode, 4-byte queue to uarttx.
// Latency: press event to tx_trigger is 2 cycles with an empty queue and an idle sender.
// Backpressure: sender waits for tx_ready; queue holds 4 bytes, further presses drop with an overflow pulse.
// Ports: clk/resetn (async active-low); col_out active-low column drive; row_in active-low row sense;
//        tx_trigger/tx_data/tx_ready handshake to uarttx; overflow one-cycle drop indication.
module keypad_scan_tx #(
  parameter int CLK_FREQ       = 12_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       resetn,
  output logic [3:0] col_out,
  input  logic [3:0] row_in,
  output logic       tx_trigger,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  output logic       overflow
);
  localparam int DWELL = CLK_FREQ / SCAN_HZ;
  localparam int DW    = $clog2(DWELL + 1);
  localparam int CW    = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [CW-1:0] DEB_MAX    = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {T_IDLE, T_WAIT, T_GAP} tx_state_t;

  // Row synchronizer
  logic [3:0] row_s1, row_s2;

  // Scan state
  logic          scan_on;
  logic [1:0]    col_idx;
  logic [DW-1:0] dwell_cnt;
  logic [15:0]   snap;
  logic [15:0]   snap_full;
  logic          sample;
  logic          snap_done;

  // Debounce state
  logic [15:0]   prev_snap;
  logic [15:0]   deb_state;
  logic [CW-1:0] stable_cnt;
  logic          deb_evt;
  logic [3:0]    key_idx;
  logic          evt_vld;
  logic [7:0]    evt_dat;

  // Queue and sender
  logic [7:0]    fifo_head;
  logic [2:0]    fifo_count;
  logic          fifo_full;
  logic          pop;
  tx_state_t     tx_state, tx_nxt;
  logic          trig_nxt;
  logic [7:0]    data_nxt;

  function automatic logic [7:0] key_ascii(input logic [3:0] idx);
    // idx = column*4 + row
    case (idx)
      4'd0:  key_ascii = 8'h31;  // r0c0 '1'
      4'd1:  key_ascii = 8'h34;  // r1c0 '4'
      4'd2:  key_ascii = 8'h37;  // r2c0 '7'
      4'd3:  key_ascii = 8'h2A;  // r3c0 '*'
      4'd4:  key_ascii = 8'h32;  // r0c1 '2'
      4'd5:  key_ascii = 8'h35;  // r1c1 '5'
      4'd6:  key_ascii = 8'h38;  // r2c1 '8'
      4'd7:  key_ascii = 8'h30;  // r3c1 '0'
      4'd8:  key_ascii = 8'h33;  // r0c2 '3'
      4'd9:  key_ascii = 8'h36;  // r1c2 '6'
      4'd10: key_ascii = 8'h39;  // r2c2 '9'
      4'd11: key_ascii = 8'h23;  // r3c2 '#'
      4'd12: key_ascii = 8'h41;  // r0c3 'A'
      4'd13: key_ascii = 8'h42;  // r1c3 'B'
      4'd14: key_ascii = 8'h43;  // r2c3 'C'
      default: key_ascii = 8'h44; // r3c3 'D'
    endcase
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
    end
  end

  assign sample    = scan_on && (dwell_cnt == DWELL_LAST);
  assign snap_done = sample && (col_idx == 2'd3);

  // Snapshot including the column being sampled this cycle, so the debounce
  // compare on the last column sees the complete matrix.
  always_comb begin
    snap_full = snap;
    snap_full[col_idx*4 +: 4] = ~row_s2;
  end

  // Event only when the newly accepted state is a single key that was not down before.
  assign deb_evt = $onehot(snap_full) && ((snap_full & deb_state) == 16'h0000);

  always_comb begin
    key_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (snap_full[i]) key_idx = 4'(i);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scan_on   <= 1'b0;
      col_idx   <= 2'd0;
      dwell_cnt <= '0;
      col_out   <= 4'hF;
      snap      <= 16'h0000;
    end else if (!scan_on) begin
      scan_on <= 1'b1;
      col_out <= 4'hE;
    end else if (sample) begin
      dwell_cnt <= '0;
      col_idx   <= col_idx + 2'd1;
      col_out   <= ~(4'b0001 << (col_idx + 2'd1));
      snap      <= snap_full;
    end else begin
      dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev_snap  <= 16'h0000;
      deb_state  <= 16'h0000;
      stable_cnt <= '0;
      evt_vld    <= 1'b0;
      evt_dat    <= 8'h00;
    end else begin
      evt_vld <= 1'b0;
      if (snap_done) begin
        prev_snap <= snap_full;
        if (snap_full == prev_snap) begin
          if (stable_cnt != DEB_MAX) stable_cnt <= stable_cnt + 1'b1;
          // Accept only on the transition into saturation.
          if (stable_cnt == DEB_MAX - 1'b1) begin
            deb_state <= snap_full;
            evt_vld   <= deb_evt;
            evt_dat   <= key_ascii(key_idx);
          end
        end else begin
          stable_cnt <= '0;
        end
      end
    end
  end

  fifo #(.WIDTH(8), .DEPTH(4)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .wr_vld (evt_vld),
    .wr_dat (evt_dat),
    .rd_rdy (pop),
    .rd_dat (fifo_head),
    .count  (fifo_count),
    .full   (fifo_full)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) overflow <= 1'b0;
    else         overflow <= evt_vld && fifo_full && !pop;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_state   <= T_IDLE;
      tx_trigger <= 1'b0;
      tx_data    <= 8'h00;
    end else begin
      tx_state   <= tx_nxt;
      tx_trigger <= trig_nxt;
      tx_data    <= data_nxt;
    end
  end

  always_comb begin
    tx_nxt   = tx_state;
    pop      = 1'b0;
    trig_nxt = 1'b0;
    data_nxt = tx_data;
    case (tx_state)
      T_IDLE: begin
        if (fifo_count != 3'd0) begin
          pop      = 1'b1;
          trig_nxt = 1'b1;
          data_nxt = fifo_head;
          tx_nxt   = T_WAIT;
        end
      end
      T_WAIT: begin
        if (tx_ready) tx_nxt = T_GAP;
      end
      T_GAP: begin
        // Gives uarttx one cycle to return to idle before the next trigger.
        tx_nxt = T_IDLE;
      end
      default: tx_nxt = T_IDLE;
    endcase
  end
endmodule

// File: tb/tb_keypad_scan_tx.sv
// Bench for keypad_scan_tx: keypad matrix model, uarttx responder model, byte scoreboard.
// DWELL = 10 cycles, one full scan = 40 cycles.
module tb_keypad_scan_tx;
  localparam int SCAN = 40;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] col_out;
  logic [3:0] row_in;
  logic       tx_trigger;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b0;
  logic       overflow;

  logic [15:0] pressed = 16'h0000;  // index = column*4 + row
  logic        hold_ready = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int trig_cnt = 0;
  int ovf_cnt = 0;
  logic [7:0] exp_q [$];

  keypad_scan_tx #(
    .CLK_FREQ       (1_000_000),
    .SCAN_HZ        (100_000),
    .DEBOUNCE_SCANS (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .col_out    (col_out),
    .row_in     (row_in),
    .tx_trigger (tx_trigger),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4 + r] && !col_out[c]) row_in[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tap_key(input int idx, input int hold_scans, input int rel_scans);
    pressed[idx] = 1'b1;
    tick(hold_scans * SCAN);
    pressed[idx] = 1'b0;
    tick(rel_scans * SCAN);
  endtask

  // uarttx responder: tx_ready pulse some cycles after each trigger, unless held off.
  initial begin : uart_model
    logic ok;
    forever begin
      @(negedge clk);
      if (resetn && tx_trigger) begin
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (!resetn) ok = 1'b0;
        end
        while (hold_ready && resetn) @(negedge clk);
        if (!resetn) ok = 1'b0;
        if (ok) begin
          @(posedge clk); #1 tx_ready = 1'b1;
          @(posedge clk); #1 tx_ready = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor: every trigger pops one expected byte; data must hold until tx_ready.
  initial begin : monitor
    logic       in_flight;
    logic       unstable;
    logic [7:0] held;
    in_flight = 1'b0;
    unstable  = 1'b0;
    held      = 8'h00;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        in_flight = 1'b0;
        continue;
      end
      if (overflow) ovf_cnt++;
      if (tx_trigger) begin
        trig_cnt++;
        check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
        in_flight = 1'b1;
        held      = tx_data;
        unstable  = 1'b0;
      end else if (in_flight) begin
        if (tx_data !== held) unstable = 1'b1;
        if (tx_ready) begin
          check("tx_data_stable", 32'(unstable), 32'd0);
          in_flight = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: time limit reached, %0d bytes still expected", exp_q.size());
    $fatal(1, "timeout");
  end

  typedef struct { int idx; logic [7:0] code; } key_t;
  key_t seq4 [6] = '{'{0, 8'h31}, '{4, 8'h32}, '{9, 8'h36}, '{14, 8'h43}, '{7, 8'h30}, '{15, 8'h44}};
  key_t seq6 [3] = '{'{2, 8'h37}, '{6, 8'h38}, '{12, 8'h41}};

  initial begin : stim
    int t0;
    int o0;
    logic [3:0] col_exp;
    logic [3:0] col_act;

    // Reset values
    tick(3);
    check("rst_col_out", 32'(col_out), 32'hF);
    check("rst_tx_trigger", 32'(tx_trigger), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Column scan sequence, including the wrap back to column 0
    resetn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      col_exp = ~(4'b0001 << (c % 4));
      col_act = col_exp;
      for (int j = 0; j < 10; j++) begin
        tick(1);
        if (col_out !== col_exp && col_act === col_exp) col_act = col_out;
      end
      check($sformatf("col_out_dwell%0d", c), 32'(col_act), 32'(col_exp));
    end
    tick(10 * SCAN);

    // Single key r1c1 with 3 cycles of contact bounce
    t0 = trig_cnt; o0 = ovf_cnt;
    exp_q.push_back(8'h35);
    for (int i = 0; i < 3; i++) begin
      pressed[5] = ~pressed[5];
      tick(1);
    end
    tap_key(5, 20, 10);
    check("t1_trigger_count", 32'(trig_cnt - t0), 32'd1);
    check("t1_no_overflow", 32'(ovf_cnt - o0), 32'd0);

    // Long hold of r3c2: one byte, nothing on release
    t0 = trig_cnt;
    exp_q.push_back(8'h23);
    pressed[11] = 1'b1;
    tick(100 * SCAN);
    check("t2_hold_count", 32'(trig_cnt - t0), 32'd1);
    t0 = trig_cnt;
    pressed[11] = 1'b0;
    tick(10 * SCAN);
    check("t2_release_count", 32'(trig_cnt - t0), 32'd0);

    // Two keys together, then partial release: no bytes
    t0 = trig_cnt;
    pressed[0]  = 1'b1;
    pressed[14] = 1'b1;
    tick(10 * SCAN);
    check("t3_multi_count", 32'(trig_cnt - t0), 32'd0);
    pressed[14] = 1'b0;
    tick(10 * SCAN);
    check("t3_partial_release_count", 32'(trig_cnt - t0), 32'd0);
    pressed[0] = 1'b0;
    tick(10 * SCAN);

    // Queue fill with tx_ready held off: 1 in flight + 4 queued, 6th dropped
    t0 = trig_cnt; o0 = ovf_cnt;
    hold_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 5) exp_q.push_back(seq4[k].code);
      tap_key(seq4[k].idx, 10, 10);
    end
    check("t4_in_flight_count", 32'(trig_cnt - t0), 32'd1);
    check("t4_overflow_pulses", 32'(ovf_cnt - o0), 32'd1);
    hold_ready = 1'b0;
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) tick(1);
    tick(50);
    check("t4_drained", 32'(exp_q.size()), 32'd0);
    check("t4_total_count", 32'(trig_cnt - t0), 32'd5);

    // Reset while waiting with 2 bytes queued
    t0 = trig_cnt;
    hold_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(seq6[k].code);
      tap_key(seq6[k].idx, 10, 10);
    end
    check("t6_in_flight_count", 32'(trig_cnt - t0), 32'd1);
    resetn = 1'b0;
    #1;
    check("t6_rst_tx_trigger", 32'(tx_trigger), 32'd0);
    check("t6_rst_tx_data", 32'(tx_data), 32'h00);
    check("t6_rst_col_out", 32'(col_out), 32'hF);
    exp_q.delete();
    tick(3);
    resetn = 1'b1;
    hold_ready = 1'b0;
    t0 = trig_cnt;
    tick(20 * SCAN);
    check("t6_no_stale_byte", 32'(trig_cnt - t0), 32'd0);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
